// File: rtl/mux_pkg.sv
// Shared defaults, occupancy states and counter width for the mux pipe stage.
package mux_pkg;
   localparam int WIDTH_DEF  = 64;
   localparam int NUM_IN_DEF = 3;
   localparam int ERR_CNT_W  = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;
endpackage

// File: rtl/mux_n_1.sv
// Combinational N:1 selector; an out-of-range select yields all-zero data.
module mux_n_1
   import mux_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NUM_IN = NUM_IN_DEF,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0][WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]             sel,
   output logic [WIDTH-1:0]             out_data
);

   always_comb begin
      out_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (sel == SEL_W'(i)) out_data = in_data[i];
      end
   end

endmodule

// File: rtl/mux_pipe_stage.sv
// Registered source-select stage behind a two-entry skid buffer, with a sticky
// out-of-range select flag and a saturating error counter.
module mux_pipe_stage
   import mux_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NUM_IN = NUM_IN_DEF,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_IN-1:0][WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]             sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         flush,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         sel_err,
   output logic [ERR_CNT_W-1:0]         err_cnt,
   output state_e                       dbg_state
);

   // Handshake: a beat moves on an edge where valid && ready on that side;
   // ready never depends on valid, and in_ready is a flop (no out_ready path).
   localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       main_q, main_d, skid_q, skid_d, sel_data;
   logic                   in_ready_q, sel_err_q, sel_err_d;
   logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                   accept, consume, sel_oor;

   mux_n_1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_mux (
      .in_data  (in_data),
      .sel      (sel),
      .out_data (sel_data)
   );

   assign accept  = in_valid && in_ready_q;
   assign consume = (state_q != EMPTY) && out_ready;
   assign sel_oor = {1'b0, sel} >= NUM_IN_L;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: if (accept) begin
            state_d = ONE;
            main_d  = sel_data;
         end
         ONE: begin
            if (accept && consume) begin
               main_d = sel_data;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = sel_data;
            end else if (consume) begin
               state_d = EMPTY;
            end
         end
         FULL: if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
         end
         default: state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
   end

   // A dropped (flushed) accept must not touch the error bookkeeping.
   always_comb begin
      sel_err_d = sel_err_q;
      err_cnt_d = err_cnt_q;
      if (accept && !flush && sel_oor) begin
         sel_err_d = 1'b1;
         if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q    <= '0;
         skid_q    <= '0;
         sel_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         main_q    <= main_d;
         skid_q    <= skid_d;
         sel_err_q <= sel_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      out_valid = (state_q != EMPTY);
      out_data  = main_q;
      in_ready  = in_ready_q;
      sel_err   = sel_err_q;
      err_cnt   = err_cnt_q;
      dbg_state = state_q;
   end

endmodule
